vending_machine_ctrl: RTL and testbench

VENDING_MACHINE_CTRL -- requirements
Module: vending_machine_ctrl

---
 rtl/vending_machine_ctrl.sv | 143 ++++++++++++++
 tb/tb_vending_machine_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_ctrl.sv
// Vending machine controller: coin credit, item selection against a price/stock
// table, single-cycle dispense, change payout handshake and per-item restocking.
module vending_machine_ctrl #(
  parameter int                    N_ITEMS    = 4,
  parameter int                    CW         = 16,
  parameter logic [N_ITEMS*CW-1:0] PRICES     = {16'd25, 16'd20, 16'd15, 16'd10},
  parameter int                    MAX_CREDIT = 100,
  parameter int                    STOCK_W    = 4,
  parameter int                    STOCK_INIT = 15,
  parameter int                    IW         = $clog2(N_ITEMS)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               coin_valid,
  input  logic [CW-1:0]      coin_value,
  input  logic               sel_valid,
  input  logic [IW-1:0]      sel_idx,
  input  logic               cancel,
  input  logic               restock_valid,
  input  logic [IW-1:0]      restock_idx,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               change_ack,
  output logic [CW-1:0]      credit,
  output logic [N_ITEMS-1:0] legal_mask,
  output logic               vend_valid,
  output logic [IW-1:0]      vend_idx,
  output logic               change_valid,
  output logic [CW-1:0]      change_value,
  output logic               coin_reject,
  output logic               sel_error,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CREDIT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

  localparam logic [IW:0] N_W   = N_ITEMS[IW:0];
  localparam logic [CW:0] MAX_C = MAX_CREDIT[CW:0];

  state_t             state_q;
  logic [STOCK_W-1:0] stock_q   [N_ITEMS];
  logic [STOCK_W-1:0] stock_nxt [N_ITEMS];
  logic [STOCK_W:0]   acc;
  logic [CW:0]        coin_sum;
  logic               coin_nz;
  logic               coin_fits;
  logic               sel_ok;
  logic [CW-1:0]      vend_diff;

  function automatic logic [CW-1:0] price_of(input int idx);
    return PRICES[idx*CW +: CW];
  endfunction

  function automatic logic [STOCK_W-1:0] sat_stock(input logic [STOCK_W:0] v);
    return v[STOCK_W] ? '1 : v[STOCK_W-1:0];
  endfunction

  assign state     = state_q;
  assign coin_nz   = coin_valid && (coin_value != '0);
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits = (coin_sum <= MAX_C);
  assign sel_ok    = sel_valid && ({1'b0, sel_idx} < N_W) && legal_mask[sel_idx];
  assign vend_diff = credit - price_of(int'(vend_idx));

  always_comb begin
    legal_mask = '0;
    for (int i = 0; i < N_ITEMS; i++)
      legal_mask[i] = (credit >= price_of(i)) && (stock_q[i] != '0);
  end

  // Dispense decrement and restock may hit the same item; add first, then saturate.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      acc = {1'b0, stock_q[i]};
      if (state_q == VEND && vend_idx == IW'(i) && stock_q[i] != '0)
        acc = acc - (STOCK_W+1)'(1);
      if (restock_valid && restock_idx == IW'(i))
        acc = acc + {1'b0, restock_qty};
      stock_nxt[i] = sat_stock(acc);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      credit       <= '0;
      change_value <= '0;
      change_valid <= 1'b0;
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      coin_reject  <= 1'b0;
      sel_error    <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_INIT[STOCK_W-1:0];
    end else begin
      vend_valid  <= 1'b0;
      coin_reject <= 1'b0;
      sel_error   <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_nxt[i];
      case (state_q)
        IDLE, CREDIT: begin
          if (state_q == CREDIT && cancel) begin
            change_value <= credit;
            change_valid <= 1'b1;
            credit       <= '0;
            state_q      <= CHANGE;
            coin_reject  <= coin_nz;
          end else if (state_q == CREDIT && sel_ok) begin
            vend_valid  <= 1'b1;
            vend_idx    <= sel_idx;
            state_q     <= VEND;
            coin_reject <= coin_nz;
          end else begin
            sel_error <= sel_valid;
            if (coin_nz) begin
              if (coin_fits) begin
                credit  <= coin_sum[CW-1:0];
                state_q <= CREDIT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
          end
        end
        VEND: begin
          change_value <= vend_diff;
          change_valid <= (vend_diff != '0);
          credit       <= '0;
          state_q      <= (vend_diff != '0) ? CHANGE : IDLE;
          coin_reject  <= coin_nz;
        end
        CHANGE: begin
          coin_reject <= coin_nz;
          if (change_ack) begin
            change_valid <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Bench for vending_machine_ctrl: directed scenarios plus a randomized run
// checked every cycle against a behavioural model of the machine's rules.
module tb_vending_machine_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        coin_valid;
  logic [15:0] coin_value;
  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic        cancel;
  logic        restock_valid;
  logic [1:0]  restock_idx;
  logic [3:0]  restock_qty;
  logic        change_ack;
  logic [15:0] credit;
  logic [3:0]  legal_mask;
  logic        vend_valid;
  logic [1:0]  vend_idx;
  logic        change_valid;
  logic [15:0] change_value;
  logic        coin_reject;
  logic        sel_error;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int prices[4] = '{10, 15, 20, 25};

  // model state
  int m_state, m_credit, m_change, m_cv, m_vidx;
  int m_stock[4];
  int e_vend, e_rej, e_err;

  vending_machine_ctrl dut (
    .clock(clock), .clear(clear),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .restock_valid(restock_valid), .restock_idx(restock_idx), .restock_qty(restock_qty),
    .change_ack(change_ack),
    .credit(credit), .legal_mask(legal_mask),
    .vend_valid(vend_valid), .vend_idx(vend_idx),
    .change_valid(change_valid), .change_value(change_value),
    .coin_reject(coin_reject), .sel_error(sel_error), .state(state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 0; coin_value = '0; sel_valid = 0; sel_idx = '0; cancel = 0;
    restock_valid = 0; restock_idx = '0; restock_qty = '0; change_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 0;
    step();
    step();
    clear = 1;
  endtask

  task automatic insert(input int v);
    coin_valid = 1; coin_value = 16'(v);
    step();
    coin_valid = 0; coin_value = '0;
  endtask

  task automatic buy(input int idx);
    insert(prices[idx]);
    sel_valid = 1; sel_idx = 2'(idx);
    step();
    sel_valid = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 0;
    #2;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (credit !== 16'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_checks++; if ({vend_valid, change_valid, coin_reject, sel_error} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {vend_valid, change_valid, coin_reject, sel_error}); end
    n_checks++; if (change_value !== 16'd0) begin n_fail++; $display("FAIL reset_change: got %0d want 0", change_value); end
    n_checks++; if (legal_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", legal_mask); end
    step();
    clear = 1;
    step();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_release_state: got %0d want 0", state); end
  endtask

  task automatic test_exact_vend();
    do_reset();
    insert(10);
    insert(5);
    n_checks++; if (credit !== 16'd15) begin n_fail++; $display("FAIL exact_credit: got %0d want 15", credit); end
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL exact_state_credit: got %0d want 1", state); end
    sel_valid = 1; sel_idx = 2'd1;
    step();
    sel_valid = 0;
    n_checks++; if (vend_valid !== 1'b1 || vend_idx !== 2'd1) begin
      n_fail++; $display("FAIL exact_vend: got valid=%b idx=%0d want valid=1 idx=1", vend_valid, vend_idx); end
    step();
    n_checks++; if (vend_valid !== 1'b0 || change_valid !== 1'b0 || state !== 2'd0 || credit !== 16'd0) begin
      n_fail++; $display("FAIL exact_after: got vend=%b cv=%b state=%0d credit=%0d want 0 0 0 0",
                         vend_valid, change_valid, state, credit); end
  endtask

  task automatic test_change();
    do_reset();
    insert(25);
    insert(10);
    sel_valid = 1; sel_idx = 2'd0;
    step();
    sel_valid = 0;
    n_checks++; if (vend_valid !== 1'b1 || vend_idx !== 2'd0) begin
      n_fail++; $display("FAIL change_vend: got valid=%b idx=%0d want valid=1 idx=0", vend_valid, vend_idx); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (change_valid !== 1'b1 || change_value !== 16'd25 || state !== 2'd3) begin
        n_fail++; $display("FAIL change_hold: got cv=%b value=%0d state=%0d want 1 25 3",
                           change_valid, change_value, state); end
    end
    change_ack = 1;
    step();
    change_ack = 0;
    n_checks++; if (change_valid !== 1'b0 || state !== 2'd0 || credit !== 16'd0) begin
      n_fail++; $display("FAIL change_ack: got cv=%b state=%0d credit=%0d want 0 0 0", change_valid, state, credit); end
  endtask

  task automatic test_overflow();
    do_reset();
    insert(25); insert(25); insert(25); insert(20);
    n_checks++; if (credit !== 16'd95) begin n_fail++; $display("FAIL overflow_fill: got %0d want 95", credit); end
    insert(10);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 16'd95) begin
      n_fail++; $display("FAIL overflow_reject: got rej=%b credit=%0d want 1 95", coin_reject, credit); end
    insert(5);
    n_checks++; if (coin_reject !== 1'b0 || credit !== 16'd100) begin
      n_fail++; $display("FAIL overflow_exact_max: got rej=%b credit=%0d want 0 100", coin_reject, credit); end
    insert(0);
    n_checks++; if (coin_reject !== 1'b0 || credit !== 16'd100) begin
      n_fail++; $display("FAIL overflow_zero_coin: got rej=%b credit=%0d want 0 100", coin_reject, credit); end
    cancel = 1;
    step();
    cancel = 0;
    n_checks++; if (state !== 2'd3 || change_valid !== 1'b1 || change_value !== 16'd100 || credit !== 16'd0) begin
      n_fail++; $display("FAIL overflow_cancel: got state=%0d cv=%b value=%0d credit=%0d want 3 1 100 0",
                         state, change_valid, change_value, credit); end
    change_ack = 1; step(); change_ack = 0;
  endtask

  task automatic test_stock();
    int vends;
    do_reset();
    vends = 0;
    for (int k = 0; k < 15; k++) begin
      insert(20);
      sel_valid = 1; sel_idx = 2'd2;
      step();
      sel_valid = 0;
      if (vend_valid === 1'b1 && vend_idx === 2'd2) vends++;
      step();
    end
    n_checks++; if (vends != 15) begin n_fail++; $display("FAIL stock_drain: got %0d vends want 15", vends); end
    insert(20);
    n_checks++; if (legal_mask !== 4'b0011) begin n_fail++; $display("FAIL stock_empty_mask: got %b want 0011", legal_mask); end
    sel_valid = 1; sel_idx = 2'd2;
    step();
    sel_valid = 0;
    n_checks++; if (sel_error !== 1'b1 || state !== 2'd1 || vend_valid !== 1'b0) begin
      n_fail++; $display("FAIL stock_sel_error: got err=%b state=%0d vend=%b want 1 1 0", sel_error, state, vend_valid); end
    restock_valid = 1; restock_idx = 2'd2; restock_qty = 4'd3;
    step();
    restock_valid = 0;
    n_checks++; if (legal_mask !== 4'b0111) begin n_fail++; $display("FAIL stock_restock_mask: got %b want 0111", legal_mask); end
    cancel = 1; step(); cancel = 0;
    change_ack = 1; step(); change_ack = 0;
  endtask

  task automatic test_priority();
    do_reset();
    insert(20);
    cancel = 1; sel_valid = 1; sel_idx = 2'd0; coin_valid = 1; coin_value = 16'd5;
    step();
    idle_inputs();
    n_checks++; if (state !== 2'd3 || change_value !== 16'd20 || change_valid !== 1'b1) begin
      n_fail++; $display("FAIL priority_cancel: got state=%0d value=%0d cv=%b want 3 20 1", state, change_value, change_valid); end
    n_checks++; if (coin_reject !== 1'b1 || vend_valid !== 1'b0 || sel_error !== 1'b0) begin
      n_fail++; $display("FAIL priority_pulses: got rej=%b vend=%b err=%b want 1 0 0", coin_reject, vend_valid, sel_error); end
    insert(10);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 16'd0) begin
      n_fail++; $display("FAIL priority_coin_in_change: got rej=%b credit=%0d want 1 0", coin_reject, credit); end
    change_ack = 1; step(); change_ack = 0;
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    for (int k = 0; k < 15; k++) buy(2);
    insert(25);
    n_checks++; if (legal_mask !== 4'b1011) begin n_fail++; $display("FAIL midrst_drained_mask: got %b want 1011", legal_mask); end
    cancel = 1; step(); cancel = 0;
    step();
    clear = 0;
    #1;
    n_checks++; if (state !== 2'd0 || change_valid !== 1'b0 || change_value !== 16'd0 || credit !== 16'd0) begin
      n_fail++; $display("FAIL midrst_async: got state=%0d cv=%b value=%0d credit=%0d want 0 0 0 0",
                         state, change_valid, change_value, credit); end
    step();
    clear = 1;
    insert(25);
    n_checks++; if (legal_mask !== 4'b1111 || change_valid !== 1'b0 || credit !== 16'd25) begin
      n_fail++; $display("FAIL midrst_restored: got mask=%b cv=%b credit=%0d want 1111 0 25", legal_mask, change_valid, credit); end
  endtask

  // Behavioural rules: apply one clock's worth of inputs to the model.
  task automatic model_step();
    int  ns[4];
    bit  coin;
    int  s, diff;
    coin = coin_valid && (coin_value != 0);
    e_vend = 0; e_rej = 0; e_err = 0;
    for (int i = 0; i < 4; i++) begin
      ns[i] = m_stock[i];
      if (m_state == 2 && m_vidx == i) ns[i] = ns[i] - 1;
      if (restock_valid && int'(restock_idx) == i) ns[i] = ns[i] + int'(restock_qty);
      if (ns[i] > 15) ns[i] = 15;
      if (ns[i] < 0) ns[i] = 0;
    end
    s = int'(sel_idx);
    if (m_state == 1 && cancel) begin
      m_change = m_credit; m_cv = 1; m_credit = 0; m_state = 3; e_rej = coin;
    end else if (m_state == 1 && sel_valid && m_credit >= prices[s] && m_stock[s] > 0) begin
      e_vend = 1; m_vidx = s; m_state = 2; e_rej = coin;
    end else if (m_state <= 1) begin
      e_err = sel_valid;
      if (coin) begin
        if (m_credit + int'(coin_value) <= 100) begin m_credit += int'(coin_value); m_state = 1; end
        else e_rej = 1;
      end
    end else if (m_state == 2) begin
      diff = m_credit - prices[m_vidx];
      m_change = diff; m_cv = (diff != 0); m_credit = 0; m_state = (diff != 0) ? 3 : 0; e_rej = coin;
    end else begin
      e_rej = coin;
      if (change_ack) begin m_cv = 0; m_state = 0; end
    end
    m_stock = ns;
  endtask

  task automatic test_random();
    int coins[5] = '{0, 5, 10, 25, 50};
    logic [3:0] e_mask;
    do_reset();
    m_state = 0; m_credit = 0; m_change = 0; m_cv = 0; m_vidx = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 15;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      coin_valid    = ($urandom % 3) == 0;
      coin_value    = 16'(coins[$urandom % 5]);
      sel_valid     = ($urandom % 4) == 0;
      sel_idx       = 2'($urandom % 4);
      cancel        = ($urandom % 12) == 0;
      restock_valid = ($urandom % 10) == 0;
      restock_idx   = 2'($urandom % 4);
      restock_qty   = 4'($urandom % 16);
      change_ack    = ($urandom % 3) == 0;
      model_step();
      step();
      for (int i = 0; i < 4; i++) e_mask[i] = (m_credit >= prices[i]) && (m_stock[i] > 0);
      n_checks++; if (state !== 2'(m_state) || credit !== 16'(m_credit)) begin
        n_fail++; $display("FAIL rand_state_credit cyc %0d: got state=%0d credit=%0d want %0d %0d",
                           cyc, state, credit, m_state, m_credit); end
      n_checks++; if (vend_valid !== 1'(e_vend) || (e_vend == 1 && vend_idx !== 2'(m_vidx))) begin
        n_fail++; $display("FAIL rand_vend cyc %0d: got valid=%b idx=%0d want %0d %0d", cyc, vend_valid, vend_idx, e_vend, m_vidx); end
      n_checks++; if (change_valid !== 1'(m_cv) || (m_cv == 1 && change_value !== 16'(m_change))) begin
        n_fail++; $display("FAIL rand_change cyc %0d: got cv=%b value=%0d want %0d %0d", cyc, change_valid, change_value, m_cv, m_change); end
      n_checks++; if (coin_reject !== 1'(e_rej) || sel_error !== 1'(e_err)) begin
        n_fail++; $display("FAIL rand_pulses cyc %0d: got rej=%b err=%b want %0d %0d", cyc, coin_reject, sel_error, e_rej, e_err); end
      n_checks++; if (legal_mask !== e_mask) begin
        n_fail++; $display("FAIL rand_mask cyc %0d: got %b want %b", cyc, legal_mask, e_mask); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    clear = 0;
    test_reset();
    test_exact_vend();
    test_change();
    test_overflow();
    test_stock();
    test_priority();
    test_reset_mid_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
